// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader: serial-to-parallel operand feeder for the matmul array multiplier.
// Assembles A (LEFT_SIZE x MIDDLE_SIZE), then B (MIDDLE_SIZE x RIGHT_SIZE), from a valid/ready
// element stream, then holds mm_en until mm_done.
// Build option: define MATLOAD_B_COLMAJOR_EN to accept B in column-major order.
module matmul_operand_loader #(
    parameter int unsigned LEFT_SIZE   = 2,
    parameter int unsigned MIDDLE_SIZE = 3,
    parameter int unsigned RIGHT_SIZE  = 4,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           s_valid,
    output logic                                           s_ready,
    input  logic [DATA_W-1:0]                              s_data,
    input  logic                                           s_last,
    output logic [LEFT_SIZE-1:0][MIDDLE_SIZE-1:0][DATA_W-1:0] mat_a,
    output logic [MIDDLE_SIZE-1:0][RIGHT_SIZE-1:0][DATA_W-1:0] mat_b,
    output logic                                           mm_en,
    input  logic                                           mm_done,
    output logic                                           busy,
    output logic                                           err
);

    localparam int unsigned LW = (LEFT_SIZE > 1) ? $clog2(LEFT_SIZE) : 1;
    localparam int unsigned MW = (MIDDLE_SIZE > 1) ? $clog2(MIDDLE_SIZE) : 1;
    localparam int unsigned RW = (RIGHT_SIZE > 1) ? $clog2(RIGHT_SIZE) : 1;

    typedef enum logic [1:0] {StLoadA, StLoadB, StRun} state_e;

    state_e state_q, state_d;

    // Separate per-matrix counters so each index is exactly as wide as its array dimension
    logic [LW-1:0] a_row_q, a_row_d;
    logic [MW-1:0] a_col_q, a_col_d;
    logic [MW-1:0] b_row_q, b_row_d;
    logic [RW-1:0] b_col_q, b_col_d;

    logic [LEFT_SIZE-1:0][MIDDLE_SIZE-1:0][DATA_W-1:0]  mat_a_q;
    logic [MIDDLE_SIZE-1:0][RIGHT_SIZE-1:0][DATA_W-1:0] mat_b_q;
    logic                                               err_q;

    logic xfer;
    logic a_col_last, a_row_last, a_done;
    logic b_row_last, b_col_last, b_done;
    logic frame_bad;

    assign xfer       = s_valid && s_ready;
    assign a_col_last = (a_col_q == MW'(MIDDLE_SIZE - 1));
    assign a_row_last = (a_row_q == LW'(LEFT_SIZE - 1));
    assign a_done     = a_row_last && a_col_last;
    assign b_row_last = (b_row_q == MW'(MIDDLE_SIZE - 1));
    assign b_col_last = (b_col_q == RW'(RIGHT_SIZE - 1));
    // Final B element is the bottom-right corner in either arrival order
    assign b_done     = b_row_last && b_col_last;

    // s_last must coincide exactly with the final B transfer
    assign frame_bad  = xfer && (s_last != ((state_q == StLoadB) && b_done));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoadA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoadA: if (xfer && a_done) state_d = StLoadB;
            StLoadB: if (xfer && b_done) state_d = StRun;
            StRun:   if (mm_done)        state_d = StLoadA;
            default:                     state_d = StLoadA;
        endcase
    end

    // Output decode: all outputs depend on state only
    always_comb begin
        s_ready = 1'b0;
        mm_en   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StLoadA, StLoadB: s_ready = 1'b1;
            StRun: begin
                mm_en = 1'b1;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    // Element position counters; each wraps to zero after its matrix completes
    always_comb begin
        a_row_d = a_row_q;
        a_col_d = a_col_q;
        b_row_d = b_row_q;
        b_col_d = b_col_q;
        if (xfer && (state_q == StLoadA)) begin
            if (a_col_last) begin
                a_col_d = '0;
                a_row_d = a_row_last ? '0 : a_row_q + LW'(1);
            end else begin
                a_col_d = a_col_q + MW'(1);
            end
        end
        if (xfer && (state_q == StLoadB)) begin
`ifdef MATLOAD_B_COLMAJOR_EN
            if (b_row_last) begin
                b_row_d = '0;
                b_col_d = b_col_last ? '0 : b_col_q + RW'(1);
            end else begin
                b_row_d = b_row_q + MW'(1);
            end
`else
            if (b_col_last) begin
                b_col_d = '0;
                b_row_d = b_row_last ? '0 : b_row_q + MW'(1);
            end else begin
                b_col_d = b_col_q + RW'(1);
            end
`endif
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_row_q <= '0;
            a_col_q <= '0;
            b_row_q <= '0;
            b_col_q <= '0;
        end else begin
            a_row_q <= a_row_d;
            a_col_q <= a_col_d;
            b_row_q <= b_row_d;
            b_col_q <= b_col_d;
        end
    end

    // Operand arrays: written one element per transfer, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else if (xfer) begin
            if (state_q == StLoadA) begin
                mat_a_q[a_row_q][a_col_q] <= s_data;
            end else if (state_q == StLoadB) begin
                mat_b_q[b_row_q][b_col_q] <= s_data;
            end
        end
    end

    // Sticky framing error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (frame_bad) begin
            err_q <= 1'b1;
        end
    end

    assign mat_a = mat_a_q;
    assign mat_b = mat_b_q;
    assign err   = err_q;

endmodule
